prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the 8-bit CPU core.
- Receives a framed byte stream over a valid/ready handshake and writes the payload into program memory (ROM image) from address 0.
- Holds the core in reset until a frame with a valid checksum has been loaded, then releases it.

Parameters:
- ADDR_W, 8, program-memory address width.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1000, max cycles allowed between accepted bytes inside a frame; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  incoming stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte.
- mem_addr  out  ADDR_W  program-memory write address.
- mem_data  out  8  program-memory write data.
- mem_we  out  1  one-cycle write strobe.
- core_rst  out  1  reset to CPU core; high = core held.
- done  out  1  load complete, sticky.
- err  out  1  frame error flag.

Behaviour:
- Reset (async, high): state=IDLE, in_ready=1, mem_addr=0, mem_data=0, mem_we=0, core_rst=1, done=0, err=0, count=0, sum=0, timer=0.
- Accept = in_valid && in_ready at a rising clk edge. All outputs are registered.
- Frame format: SYNC_BYTE, LEN (N payload bytes, 0..255), N payload bytes, CSUM.
- Frame is valid iff (LEN + sum of payload + CSUM) mod 256 == 0.

States:
- IDLE:
  - Accepted byte == SYNC_BYTE -> LEN, clear err.
  - Any other accepted byte is discarded; stay in IDLE.
- LEN:
  - Accept -> sum=byte, count=0, N=byte.
  - N==0 -> CSUM; otherwise -> DATA.
- DATA:
  - Each accept registers mem_addr=count, mem_data=byte, and pulses mem_we=1 on the next cycle only.
  - Same accept updates sum+=byte and count+=1.
  - The accept that makes count==N -> CSUM.
  - Payload byte k is written to address k (k=0..N-1).
- CSUM:
  - Accept and (sum+byte) mod 256 == 0 -> DONE.
  - Accept and nonzero -> ERR.
- DONE:
  - done=1, core_rst=0 (both change on the cycle after the CSUM accept), in_ready=0.
  - Terminal until rst.
- ERR:
  - err=1, core_rst stays 1, in_ready=1.
  - Behaves as IDLE: a SYNC_BYTE accept -> LEN with err cleared; other bytes are discarded.

Timeout:
- In LEN/DATA/CSUM, timer increments each cycle without an accept and clears on each accept.
- timer reaching TIMEOUT-1 -> ERR (count/sum discarded). Timer is idle in IDLE/ERR/DONE.

Boundary rules:
- SYNC_BYTE value inside LEN/DATA/CSUM is treated as data; there is no resync mid-frame.
- Memory writes already performed by an aborted frame are not rolled back. A retry overwrites from address 0.
- in_valid high with in_ready low (DONE) is ignored; no state change.
- mem_we never asserts outside DATA-driven pulses. Back-to-back accepts give back-to-back mem_we pulses.
- A timeout expiring on the same cycle as an accept: the accept wins and the timer clears.
- rst mid-frame: immediate return to reset values; core_rst=1.
- Arithmetic: sum is 8-bit wraparound; count is 8-bit (N<=255, no overflow).

Test Plan:
- Reset -> core_rst=1, in_ready=1, done=0, err=0, mem_we=0.
- Good frame A5,03,11,22,33,97 sent back-to-back -> mem_we pulses with (0,11),(1,22),(2,33); done=1 and core_rst=0 one cycle after the 97 accept; in_ready=0.
- Bad checksum A5,02,AA,BB,00 -> err=1, core_rst=1, done=0. Then A5,01,5C,A3 -> err clears on the A5 accept; write (0,5C); done=1.
- Zero-length frame A5,00,00 -> no mem_we, done=1. Leading garbage 00,FF before A5 is discarded with no writes.
- Timeout with TIMEOUT=8: A5,02,10 then idle 8 cycles -> err=1 with one write (0,10) performed. Subsequent A5 restarts the frame.
- Valid stalls (gaps < TIMEOUT) between payload bytes -> same memory image as back-to-back. A5 inside the payload is written as data. rst asserted mid-DATA -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: parses SYNC/LEN/payload/CSUM frames into program memory and releases core reset on a good checksum.
// All outputs are registered; mem_we pulses one cycle after each payload accept; in_ready drops only once loading is done.
module prog_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        len_q, len_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic       accept;
  logic       in_frame;
  logic       tmo;
  logic [7:0] count_inc;
  logic [7:0] csum_chk;

  assign accept    = in_valid && in_ready_q;
  assign in_frame  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign tmo       = (timer_q == TW'(TIMEOUT - 1));
  assign count_inc = count_q + 8'd1;
  assign csum_chk  = sum_q + in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      sum_q      <= '0;
      len_q      <= '0;
      timer_q    <= '0;
      in_ready_q <= 1'b1;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      len_q      <= len_d;
      timer_q    <= timer_d;
      in_ready_q <= in_ready_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // An accept always beats a timeout expiring on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERR: if (accept && in_data == SYNC_BYTE) state_d = S_LEN;
      S_LEN: begin
        if (accept)   state_d = (in_data == 8'd0) ? S_CSUM : S_DATA;
        else if (tmo) state_d = S_ERR;
      end
      S_DATA: begin
        if (accept) begin
          if (count_inc == len_q) state_d = S_CSUM;
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_CSUM: begin
        if (accept)   state_d = (csum_chk == 8'd0) ? S_DONE : S_ERR;
        else if (tmo) state_d = S_ERR;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    sum_d      = sum_q;
    len_d      = len_q;
    timer_d    = '0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;

    if (in_frame && !accept && !tmo) timer_d = timer_q + TW'(1);

    if (accept && state_q == S_LEN) begin
      sum_d   = in_data;
      count_d = '0;
      len_d   = in_data;
    end
    if (accept && state_q == S_DATA) begin
      sum_d      = csum_chk;
      count_d    = count_inc;
      mem_addr_d = ADDR_W'(count_q);
      mem_data_d = in_data;
      mem_we_d   = 1'b1;
    end
    // Aborted frame: partial progress is dropped; memory writes already issued stay.
    if (in_frame && state_d == S_ERR) begin
      count_d = '0;
      sum_d   = '0;
    end

    in_ready_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    core_rst_d = (state_d != S_DONE);
    err_d      = (state_d == S_ERR);
  end

  assign in_ready = in_ready_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;
  assign core_rst = core_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: byte table with expected flags, plus a write scoreboard and multi-cycle corner sequences.
module tb_prog_loader;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_we;
  logic       core_rst;
  logic       done;
  logic       err;

  prog_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_before;
    logic [7:0] d;
    int         gap;
    logic       wr;
    logic [7:0] addr;
    logic       done;
    logic       err;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [7:0] d, input int gap,
                     input logic wr, input logic [7:0] a, input logic dn, input logic er);
    vec_t v;
    v.rst_before = r; v.d = d; v.gap = gap; v.wr = wr; v.addr = a; v.done = dn; v.err = er;
    vecs.push_back(v);
  endtask

  // Callers are positioned at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_stall: in_ready stuck low for byte %02h", b);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we: addr %02h data %02h, no write expected", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        chk8("wr_addr", mem_addr, e[15:8]);
        chk8("wr_data", mem_data, e[7:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Garbage, bad checksum, then recovery frame.
    add(0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(0, 8'hFF, 0, 0, 8'h00, 0, 0);
    add(0, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 8'h02, 0, 0, 8'h00, 0, 0);
    add(0, 8'hAA, 0, 1, 8'h00, 0, 0);
    add(0, 8'hBB, 0, 1, 8'h01, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1);
    add(0, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 8'h01, 0, 0, 8'h00, 0, 0);
    add(0, 8'h5C, 0, 1, 8'h00, 0, 0);
    add(0, 8'hA3, 0, 0, 8'h00, 1, 0);
    // Good frame back-to-back.
    add(1, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 8'h03, 0, 0, 8'h00, 0, 0);
    add(0, 8'h11, 0, 1, 8'h00, 0, 0);
    add(0, 8'h22, 0, 1, 8'h01, 0, 0);
    add(0, 8'h33, 0, 1, 8'h02, 0, 0);
    add(0, 8'h97, 0, 0, 8'h00, 1, 0);
    // Same frame with stalls; the 7-cycle gap lands the accept on the timeout edge.
    add(1, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 8'h03, 2, 0, 8'h00, 0, 0);
    add(0, 8'h11, 3, 1, 8'h00, 0, 0);
    add(0, 8'h22, 5, 1, 8'h01, 0, 0);
    add(0, 8'h33, 7, 1, 8'h02, 0, 0);
    add(0, 8'h97, 4, 0, 8'h00, 1, 0);
    // Zero-length frame.
    add(1, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 1, 0);
    // Sync value inside the payload is plain data.
    add(1, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 8'h02, 0, 0, 8'h00, 0, 0);
    add(0, 8'hA5, 0, 1, 8'h00, 0, 0);
    add(0, 8'h5A, 0, 1, 8'h01, 0, 0);
    add(0, 8'hFF, 0, 0, 8'h00, 1, 0);

    repeat (2) @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_core_rst", core_rst, 1'b1);
    chk1("rst_done",     done,     1'b0);
    chk1("rst_err",      err,      1'b0);
    chk1("rst_mem_we",   mem_we,   1'b0);
    chk8("rst_mem_addr", mem_addr, 8'h00);
    chk8("rst_mem_data", mem_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      if (vecs[i].wr) push_wr(vecs[i].addr, vecs[i].d);
      send(vecs[i].d, vecs[i].gap);
      chk1("done",     done,     vecs[i].done);
      chk1("err",      err,      vecs[i].err);
      chk1("core_rst", core_rst, !vecs[i].done);
      chk1("in_ready", in_ready, !vecs[i].done);
    end

    // DONE is terminal: offered bytes are ignored.
    in_data  = 8'hA5;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk1("hold_done",     done,     1'b1);
    chk1("hold_in_ready", in_ready, 1'b0);
    chk1("hold_core_rst", core_rst, 1'b0);
    chk1("hold_err",      err,      1'b0);

    // Timeout mid-payload, then a retry from address 0.
    do_reset();
    send(8'hA5, 0);
    send(8'h02, 0);
    push_wr(8'h00, 8'h10);
    send(8'h10, 0);
    repeat (6) @(negedge clk);
    chk1("tmo_early_err", err, 1'b0);
    repeat (2) @(negedge clk);
    chk1("tmo_err",      err,      1'b1);
    chk1("tmo_core_rst", core_rst, 1'b1);
    chk1("tmo_done",     done,     1'b0);
    chk1("tmo_in_ready", in_ready, 1'b1);
    send(8'hA5, 3);
    chk1("retry_err_clr", err, 1'b0);
    send(8'h01, 0);
    push_wr(8'h00, 8'h5C);
    send(8'h5C, 0);
    send(8'hA3, 0);
    chk1("retry_done", done, 1'b1);

    // Asynchronous reset in the middle of the payload.
    do_reset();
    send(8'hA5, 0);
    send(8'h03, 0);
    push_wr(8'h00, 8'h11);
    send(8'h11, 0);
    in_data  = 8'h22;
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk1("arst_mem_we",   mem_we,   1'b0);
    chk8("arst_mem_addr", mem_addr, 8'h00);
    chk8("arst_mem_data", mem_data, 8'h00);
    chk1("arst_in_ready", in_ready, 1'b1);
    chk1("arst_core_rst", core_rst, 1'b1);
    chk1("arst_done",     done,     1'b0);
    chk1("arst_err",      err,      1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_empty: %0d writes outstanding, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
